turn_scheduler: RTL and testbench
=================================

# turn_scheduler

Round-robin turn scheduler that passes a single exclusive token ("turn") between N players in strict rotation, the clocked RTL counterpart of the ping/pong event-handshake tests used to exercise the dynamic scheduler. After a start pulse and a programmable delay, it grants one requesting player at a time, waits for that player's completion acknowledge, then hands the turn to the next requester. It stops after a fixed number of completed turns. It sits between a stimulus/test controller and a set of player agents that share one resource.

## Interface
- N_PLAYERS, 2, number of players; must be at least 2.
- MAX_TURNS, 10, completed turns before `done`; must be at least 1.
- START_DELAY, 100, idle cycles between start and the first arbitration; 0 is legal.
- TIMEOUT, 255, maximum cycles in WAIT_ACK before the turn is forfeited (macro-gated).
- clk  input  1  single clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a session; sampled only in IDLE or DONE.
- req  input  N_PLAYERS  per-player request for a turn.
- ack  input  N_PLAYERS  per-player turn-complete; only the granted bit is honoured.
- grant  output  N_PLAYERS  one-hot or zero; registered.
- cur_player  output  max(1,$clog2(N_PLAYERS))  index of the last or current granted player.
- turn_cnt  output  $clog2(MAX_TURNS+1)  completed turns this session.
- busy  output  1  high in DELAY, ARB and WAIT_ACK.
- done  output  1  high in DONE.
- timeout_err  output  1  sticky forfeit flag; constant 0 when the feature is compiled out.

## Operation
- States: IDLE, DELAY, ARB, WAIT_ACK, DONE.
- IDLE or DONE, start=1:
  - clear turn_cnt, the round-robin pointer (next=0) and timeout_err.
  - load delay_cnt with START_DELAY and go to DELAY.
- DELAY: if delay_cnt==0, go to ARB; otherwise decrement. DELAY therefore lasts START_DELAY+1 cycles.
- ARB:
  - Search req starting at the pointer, wrapping modulo N_PLAYERS.
  - On the first hit p: set grant[p], set cur_player=p and go to WAIT_ACK.
  - With no req, remain in ARB indefinitely with grant=0.
- WAIT_ACK, on ack[cur_player]=1:
  - clear grant and increment turn_cnt.
  - set pointer=(cur_player+1) mod N.
  - go to DONE if the new turn_cnt equals MAX_TURNS, else ARB.
- Acks on non-granted bits are ignored. Dropping req while granted does not revoke the grant.
- start outside IDLE/DONE is ignored. DONE holds all outputs until the next start.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - state=IDLE.
  - grant=0, cur_player=0, turn_cnt=0, busy=0, done=0, timeout_err=0, pointer=0.
- Reset asserted mid-operation aborts immediately: grant drops asynchronously and there is no partial count.
- Grant latency: grant is high on the edge following the first ARB cycle with any req.
- Minimum turn is 2 cycles: one in ARB, one in WAIT_ACK with ack already high.
- ack high in the same cycle grant first appears counts as completion.
- Back-to-back turns: grant goes low for exactly one cycle (ARB) between players, never two bits high.
- Pointer wraps from N_PLAYERS-1 to 0. With only one requester, that player receives every turn.
- turn_cnt saturates at MAX_TURNS and never wraps.

## Configuration
- TURN_SCHED_TIMEOUT_EN defined:
  - a watchdog counter, $clog2(TIMEOUT+1) bits, clears on WAIT_ACK entry and increments each WAIT_ACK cycle.
  - At count==TIMEOUT without ack: clear grant, set timeout_err (sticky), set pointer=cur_player+1 and go to ARB.
  - turn_cnt is not incremented for a forfeited turn.
  - ack arriving in the same cycle as the timeout wins: normal completion, no error.
- Macro undefined: WAIT_ACK waits indefinitely; timeout_err is tied to 0; no watchdog logic is generated.

## Structure
- Shared package turn_sched_pkg holds:
  - the state enum typedef (IDLE, DELAY, ARB, WAIT_ACK, DONE).
  - the width helper function for cur_player and turn_cnt.
- One sub-module, rr_pick: combinational round-robin selector with inputs req and pointer, outputs valid and index. It is reused by other arbiters in the test suite.

## Test plan
- Reset asserted mid-WAIT_ACK (grant[1]=1) -> grant=0 within the same cycle; all outputs at reset values; a fresh start reruns cleanly.
- Defaults, both req=1, each player acks 1 cycle after grant, start at cycle 0:
  - grant sequence 0,1,0,1… (10 grants).
  - done=1 with turn_cnt=10.
  - first grant edge at cycle START_DELAY+3.
- N_PLAYERS=3, req=3'b101 -> grants alternate 0,2,0,2; player 1 is never granted. Raising req[1] mid-session -> order 0,1,2 from the next rotation.
- req=0 after DELAY -> stays in ARB with busy=1 and grant=0 for 50 cycles. Then req[1]=1 -> grant[1] on the next edge.
- TURN_SCHED_TIMEOUT_EN, TIMEOUT=8, player 0 never acks:
  - grant[0] is dropped after 8 WAIT_ACK cycles.
  - timeout_err=1, turn_cnt unchanged.
  - next grant goes to player 1.
- Session complete, start pulsed again -> counters and timeout_err clear, done=0, a new 10-turn session runs. A start pulse mid-session has no effect.

Source files
------------

// File: rtl/turn_scheduler_pkg.sv
// Shared types for the turn scheduler: FSM state encoding and the index-width helper.
package turn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    ARB,
    WAIT_ACK,
    DONE
  } state_t;

  // Width of an index/count able to hold values 0..n-1, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/turn_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector; returns the first set req bit at or after pointer.
module rr_pick #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] pointer,
  output logic         valid,
  output logic [W-1:0] index
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate req so the pointer position lands at bit 0, then take the lowest set bit.
  always_comb begin
    dbl   = {req, req} >> pointer;
    rot   = dbl[N-1:0];
    valid = |rot;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) index = W'((int'(pointer) + i) % N);
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: passes one exclusive turn among N players in round-robin order for MAX_TURNS turns.
// Define TURN_SCHED_TIMEOUT_EN to add the WAIT_ACK watchdog that forfeits stalled turns.
module turn_scheduler
  import turn_sched_pkg::*;
#(
  parameter int unsigned N_PLAYERS   = 2,
  parameter int unsigned MAX_TURNS   = 10,
  parameter int unsigned START_DELAY = 100,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [N_PLAYERS-1:0]                   req,
  input  logic [N_PLAYERS-1:0]                   ack,
  output logic [N_PLAYERS-1:0]                   grant,
  output logic [idx_width(N_PLAYERS)-1:0]        cur_player,
  output logic [idx_width(MAX_TURNS + 1)-1:0]    turn_cnt,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   timeout_err
);

  localparam int unsigned CW = idx_width(N_PLAYERS);
  localparam int unsigned TW = idx_width(MAX_TURNS + 1);
  localparam int unsigned DW = idx_width(START_DELAY + 1);

  if (N_PLAYERS < 2 || MAX_TURNS < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("turn_scheduler: unsupported parameter combination");
  end

  state_t          state;
  logic [CW-1:0]   pointer;
  logic [DW-1:0]   delay_cnt;
  logic            pick_valid;
  logic [CW-1:0]   pick_index;
  logic            ack_hit;
  logic            wd_expire;
  logic [CW-1:0]   next_ptr;

  rr_pick #(.N(N_PLAYERS), .W(CW)) u_pick (
    .req     (req),
    .pointer (pointer),
    .valid   (pick_valid),
    .index   (pick_index)
  );

  // grant is one-hot in WAIT_ACK, so masking ack with it honours only the granted player.
  assign ack_hit  = |(ack & grant);
  assign next_ptr = (cur_player == CW'(N_PLAYERS - 1)) ? '0 : cur_player + CW'(1);

`ifdef TURN_SCHED_TIMEOUT_EN
  localparam int unsigned WW = idx_width(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;

  // Counts WAIT_ACK cycles already spent; expiry fires in the TIMEOUT-th cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wd_cnt <= '0;
    else if (state != WAIT_ACK) wd_cnt <= '0;
    else                       wd_cnt <= wd_cnt + WW'(1);
  end

  assign wd_expire = (wd_cnt == WW'(TIMEOUT - 1));
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      cur_player <= '0;
      turn_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pointer    <= '0;
      delay_cnt  <= '0;
`ifdef TURN_SCHED_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            turn_cnt  <= '0;
            pointer   <= '0;
            delay_cnt <= DW'(START_DELAY);
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= DELAY;
`ifdef TURN_SCHED_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
          end
        end
        DELAY: begin
          if (delay_cnt == '0) state <= ARB;
          else                 delay_cnt <= delay_cnt - DW'(1);
        end
        ARB: begin
          if (pick_valid) begin
            grant      <= N_PLAYERS'(1) << pick_index;
            cur_player <= pick_index;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // A completing ack takes priority over a watchdog expiry in the same cycle.
          if (ack_hit) begin
            grant   <= '0;
            pointer <= next_ptr;
            if (turn_cnt != TW'(MAX_TURNS)) turn_cnt <= turn_cnt + TW'(1);
            if (turn_cnt == TW'(MAX_TURNS - 1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= ARB;
            end
          end else if (wd_expire) begin
            grant   <= '0;
            pointer <= next_ptr;
            state   <= ARB;
`ifdef TURN_SCHED_TIMEOUT_EN
            timeout_err <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler: randomized sessions scored against a turn-level rotation model.
module tb_turn_scheduler;

  localparam int unsigned N  = 3;
  localparam int unsigned MT = 10;
  localparam int unsigned SD = 5;
  localparam int unsigned TO = 8;
  localparam int unsigned CW = 2;
  localparam int unsigned TW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  req   = '0;
  logic [N-1:0]  ack   = '0;
  logic [N-1:0]  grant;
  logic [CW-1:0] cur_player;
  logic [TW-1:0] turn_cnt;
  logic          busy;
  logic          done;
  logic          timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  turn_scheduler #(
    .N_PLAYERS   (N),
    .MAX_TURNS   (MT),
    .START_DELAY (SD),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .req         (req),
    .ack         (ack),
    .grant       (grant),
    .cur_player  (cur_player),
    .turn_cnt    (turn_cnt),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rotation: first requester scanning upward from ptr, wrapping mod N.
  function automatic int first_pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < int'(N); i++) begin
      int j;
      j = (ptr + i) % int'(N);
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] mask_for(input int mode, input int t);
    logic [N-1:0] m;
    case (mode)
      0:       m = 3'b111;
      1:       m = (t < 4) ? 3'b101 : 3'b111;
      default: m = N'($urandom_range(1, (1 << N) - 1));
    endcase
    return m;
  endfunction

  // One full session from IDLE/DONE: random ack latency, ack noise, req churn and ignored start pulses.
  task automatic run_session(input int mode);
    int           ptr;
    int           p;
    int           lat;
    logic [N-1:0] bit_p;
    ptr   = 0;
    ack   = '0;
    req   = mask_for(mode, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_clr", done, 0);
    check("cnt_clr", turn_cnt, 0);
    check("err_clr", timeout_err, 0);
    check("busy_delay", busy, 1);
    for (int c = 2; c <= int'(SD) + 2; c++) begin
      tick();
      check("no_early_grant", grant, 0);
    end
    for (int t = 0; t < int'(MT); t++) begin
      if (t > 0) req = mask_for(mode, t);
      p = first_pick(req, ptr);
      tick();
      bit_p = N'(1) << p;
      check("grant", grant, bit_p);
      check("cur_player", cur_player, p);
      check("busy", busy, 1);
      lat = $urandom_range(0, 3);
      ack = (N'($urandom) & ~bit_p) | ((lat == 0) ? bit_p : '0);
      req = N'($urandom);
      for (int k = 1; k <= lat; k++) begin
        start = ($urandom_range(0, 3) == 0);
        tick();
        check("grant_hold", grant, bit_p);
        ack = (N'($urandom) & ~bit_p) | ((k == lat) ? bit_p : '0);
      end
      start = 1'b0;
      tick();
      ack = '0;
      check("grant_drop", grant, 0);
      check("turn_cnt", turn_cnt, t + 1);
      ptr = (p + 1) % int'(N);
    end
    check("done", done, 1);
    check("busy_end", busy, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("done_hold", done, 1);
      check("cnt_sat", turn_cnt, MT);
      check("grant_idle", grant, 0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_cur"}, cur_player, 0);
    check({tag, "_cnt"}, turn_cnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, timeout_err, 0);
  endtask

  task automatic idle_arb_then_reset();
    req   = '0;
    ack   = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (SD + 1) tick();
    for (int c = 0; c < 50; c++) begin
      tick();
      check("arb_busy", busy, 1);
      check("arb_nogrant", grant, 0);
    end
    req = 3'b010;
    tick();
    check("late_grant", grant, 3'b010);
    ack = 3'b010;
    tick();
    ack = '0;
    check("late_cnt", turn_cnt, 1);
    check("late_drop", grant, 0);
    tick();
    check("solo_regrant", grant, 3'b010);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_grant", grant, 0);
  endtask

`ifdef TURN_SCHED_TIMEOUT_EN
  task automatic timeout_test();
    req   = 3'b001;
    ack   = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (SD + 1) tick();
    tick();
    check("to_grant", grant, 3'b001);
    for (int k = 1; k < int'(TO); k++) begin
      tick();
      check("to_hold", grant, 3'b001);
    end
    tick();
    check("to_drop", grant, 0);
    check("to_err", timeout_err, 1);
    check("to_cnt", turn_cnt, 0);
    req = 3'b011;
    tick();
    check("to_next", grant, 3'b010);
    ack = 3'b010;
    tick();
    ack = '0;
    check("to_sticky", timeout_err, 1);
    check("to_cnt2", turn_cnt, 1);
    req = 3'b001;
    tick();
    check("to_grant2", grant, 3'b001);
    for (int k = 1; k < int'(TO); k++) tick();
    ack = 3'b001;
    tick();
    ack = '0;
    check("to_ack_wins", turn_cnt, 2);
    check("to_ack_drop", grant, 0);
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    run_session(0);
    run_session(1);
    for (int s = 0; s < 4; s++) run_session(2);
    idle_arb_then_reset();
    run_session(0);
`ifdef TURN_SCHED_TIMEOUT_EN
    timeout_test();
    run_session(2);
`else
    check("err_tied", timeout_err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
